id_stage_piped: RTL and testbench
=================================

// Module: id_stage_piped
// PURPOSE
//  Parametrised decode stage with registered ID/EX outputs. Decodes one RV32 instruction per
//  cycle, reads operands from an internal NUM_REGS x XLEN register file, generates the
//  immediate, and holds the result in a valid-tagged ID/EX pipeline register with stall/flush.
//  Sits between IF/ID and execute; writeback drives the register-file write port.
// PARAMETERS
//  XLEN      32  datapath/register width (>=32); immediates sign-extended to XLEN
//  NUM_REGS  32  architectural registers: 32 (RV32I) or 16 (RV32E); x0 always reads 0
// PORTS
//  clk               in   1     clock, rising edge
//  rst               in   1     synchronous, active-high reset
//  if_valid          in   1     instruction_in/pc_in hold a real instruction
//  instruction_in    in   32    raw instruction from IF/ID
//  pc_in             in   XLEN  PC of instruction_in
//  id_stall          in   1     hold the ID/EX register (hazard unit)
//  id_flush          in   1     load a bubble into the ID/EX register (branch redirect)
//  reg_file_wr_en    in   1     writeback enable
//  reg_file_wr_addr  in   5     writeback register index
//  reg_file_wr_data  in   XLEN  writeback data
//  id_ex_valid       out  1     ID/EX holds a real instruction
//  id_ex_pc          out  XLEN  registered PC
//  id_ex_op1/op2     out  XLEN  registered rs1/rs2 values
//  id_ex_rs1/rs2/rd  out  5     registered register indices
//  id_ex_imm         out  XLEN  registered immediate
//  id_ex_opcode      out  7     registered opcode
//  id_ex_func3       out  3     registered func3
//  id_ex_func7       out  7     registered func7
//  id_ex_invalid     out  1     registered illegal-instruction flag
// BEHAVIOUR
//  - Effective instr = 32'h00000013 (ADDI x0,x0,0) when !if_valid, else instruction_in; all
//    decode, operand read and immediate generation are combinational on it.
//  - ID/EX update priority per rising edge: rst > id_flush > id_stall > load. Latency 1 cycle.
//  - rst: every output 0 (valid=0, opcode=0); register file cleared to 0 over the same edge.
//  - id_flush (even with id_stall): valid<=0, opcode<=7'h13, all other outputs 0.
//  - id_stall (no flush): every ID/EX output holds; register-file write still performed.
//  - load: valid<=if_valid; all fields from effective instr; invalid<=if_valid & illegal.
//  - Immediate by opcode: STORE 0100011 S; BRANCH 1100011 B (bit0=0); JAL 1101111 J (bit0=0);
//    LUI 0110111 / AUIPC 0010111 {inst[31:12],12'b0} sign-extended to XLEN; else I-type.
//  - illegal = inst[1:0]!=2'b11, or opcode not in {LUI,AUIPC,JAL,JALR 1100111,BRANCH,
//    LOAD 0000011,STORE,OP-IMM 0010011,OP 0110011}, or any used rs1/rs2/rd index >= NUM_REGS.
//  - Register file: write at clk edge when wr_en && wr_addr!=0 && wr_addr<NUM_REGS; other
//    writes ignored. Read index 0 or >=NUM_REGS returns 0.
//  - Simultaneous write and read of same register: see CONFIGURATION.
// CONFIGURATION
//  ID_WB_BYPASS_EN defined: if reg_file_wr_en && wr_addr==rsN && rsN!=0 && rsN<NUM_REGS,
//   the operand read returns reg_file_wr_data in that same cycle (write-through).
//  ID_WB_BYPASS_EN undefined: operand returns the pre-write array value; the external
//   forwarding unit covers the WB->ID hazard.
// TESTING
//  - rst held 2 cycles -> all outputs 0; read of x1..x31 after reset -> 0.
//  - write x5=32'hDEADBEEF, next cycle if_valid=1 instr 32'h00028333 (add x6,x5,x0)
//    -> next edge valid=1, op1=32'hDEADBEEF, op2=0, rd=6, invalid=0.
//  - same-cycle write x5=32'h00000055 with add x6,x5,x0 -> op1=32'h55 with ID_WB_BYPASS_EN,
//    old x5 value without it; write to x0 then read x0 -> 0.
//  - instr 32'hFE000EE3 (beq -4) -> imm=32'hFFFFFFFC; 32'h123450B7 (lui x1) -> imm=32'h12345000.
//  - load A, then id_stall=1 for 3 cycles with new instr B -> outputs stay A; id_flush=1 with
//    id_stall=1 -> valid=0, opcode=7'h13 next edge.
//  - NUM_REGS=16: instr 32'h000A0013 (addi x0,x20,0) -> invalid=1; opcode 7'h7F -> invalid=1;
//    if_valid=0 -> valid=0, invalid=0.

Source files
------------

// File: rtl/id_stage_piped_if.sv
// Bus bundle for id_stage_piped: fetch-side inputs, writeback port and the ID/EX register outputs.
// The master drives the instruction/control/writeback inputs; the slave is the decode stage.
interface id_stage_piped_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     instruction_in;
  logic [XLEN-1:0] pc_in;
  logic            id_stall;
  logic            id_flush;
  logic            reg_file_wr_en;
  logic [4:0]      reg_file_wr_addr;
  logic [XLEN-1:0] reg_file_wr_data;

  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc;
  logic [XLEN-1:0] id_ex_op1;
  logic [XLEN-1:0] id_ex_op2;
  logic [4:0]      id_ex_rs1;
  logic [4:0]      id_ex_rs2;
  logic [4:0]      id_ex_rd;
  logic [XLEN-1:0] id_ex_imm;
  logic [6:0]      id_ex_opcode;
  logic [2:0]      id_ex_func3;
  logic [6:0]      id_ex_func7;
  logic            id_ex_invalid;

  modport master (
    output if_valid, instruction_in, pc_in, id_stall, id_flush,
           reg_file_wr_en, reg_file_wr_addr, reg_file_wr_data,
    input  id_ex_valid, id_ex_pc, id_ex_op1, id_ex_op2, id_ex_rs1, id_ex_rs2, id_ex_rd,
           id_ex_imm, id_ex_opcode, id_ex_func3, id_ex_func7, id_ex_invalid
  );

  modport slave (
    input  if_valid, instruction_in, pc_in, id_stall, id_flush,
           reg_file_wr_en, reg_file_wr_addr, reg_file_wr_data,
    output id_ex_valid, id_ex_pc, id_ex_op1, id_ex_op2, id_ex_rs1, id_ex_rs2, id_ex_rd,
           id_ex_imm, id_ex_opcode, id_ex_func3, id_ex_func7, id_ex_invalid
  );
endinterface

// File: rtl/id_stage_piped.sv
// RV32 decode stage: register file, immediate generation, illegal check and a registered ID/EX stage.
// Optional macro ID_WB_BYPASS_EN makes a same-cycle writeback visible to the operand read.
module id_stage_piped #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               rst,
  id_stage_piped_if.slave    bus
);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          AW        = $clog2(NUM_REGS);
  localparam logic [5:0]  NR        = 6'(NUM_REGS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic            invalid;
  } idex_t;

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [31:0]     imm32;
  logic            known, uses_rd, uses_rs1, uses_rs2, illegal;
  logic            wr_hit;
  logic [NUM_REGS-1:0] wr_sel;
  logic [XLEN-1:0] regs_q [NUM_REGS];
  idex_t           idex_q, idex_d, bubble;

  function automatic logic idx_ok(input logic [4:0] idx);
    return {1'b0, idx} < NR;
  endfunction

  assign inst   = bus.if_valid ? bus.instruction_in : NOP_INSTR;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign wr_hit = bus.reg_file_wr_en && (bus.reg_file_wr_addr != 5'd0) && idx_ok(bus.reg_file_wr_addr);

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wsel
      assign wr_sel[gi] = wr_hit && (bus.reg_file_wr_addr == 5'(gi));
    end
  endgenerate

  // Reset clears the whole file, so this stays in fabric registers rather than block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst)            regs_q[i] <= '0;
      else if (wr_sel[i]) regs_q[i] <= bus.reg_file_wr_data;
    end
  end

  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
    logic [XLEN-1:0] val;
    val = '0;
    if (idx != 5'd0 && idx_ok(idx)) begin
      val = regs_q[idx[AW-1:0]];
`ifdef ID_WB_BYPASS_EN
      if (wr_hit && bus.reg_file_wr_addr == idx) val = bus.reg_file_wr_data;
`endif
    end
    return val;
  endfunction

  always_comb begin
    imm32 = {{20{inst[31]}}, inst[31:20]};
    case (opcode)
      OPC_STORE:           imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:          imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_JAL:             imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OPC_LUI, OPC_AUIPC:  imm32 = {inst[31:12], 12'b0};
      default:             imm32 = {{20{inst[31]}}, inst[31:20]};
    endcase
  end

  always_comb begin
    known    = 1'b1;
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL:      uses_rd = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM:    begin uses_rd = 1'b1; uses_rs1 = 1'b1; end
      OPC_BRANCH, OPC_STORE:            begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_OP:                           begin uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      default:                          known = 1'b0;
    endcase
    illegal = (inst[1:0] != 2'b11) || !known
            || (uses_rd && !idx_ok(rd)) || (uses_rs1 && !idx_ok(rs1)) || (uses_rs2 && !idx_ok(rs2));
  end

  always_comb begin
    idex_d         = '0;
    idex_d.valid   = bus.if_valid;
    idex_d.pc      = bus.pc_in;
    idex_d.op1     = read_reg(rs1);
    idex_d.op2     = read_reg(rs2);
    idex_d.rs1     = rs1;
    idex_d.rs2     = rs2;
    idex_d.rd      = rd;
    idex_d.imm     = XLEN'(signed'(imm32));
    idex_d.opcode  = opcode;
    idex_d.func3   = inst[14:12];
    idex_d.func7   = inst[31:25];
    idex_d.invalid = bus.if_valid & illegal;
  end

  // Flush bubble carries the canonical NOP opcode so execute sees an ADDI rather than opcode 0.
  always_comb begin
    bubble        = '0;
    bubble.opcode = OPC_OPIMM;
  end

  always_ff @(posedge clk) begin
    if (rst)               idex_q <= '0;
    else if (bus.id_flush) idex_q <= bubble;
    else if (!bus.id_stall) idex_q <= idex_d;
  end

  assign bus.id_ex_valid   = idex_q.valid;
  assign bus.id_ex_pc      = idex_q.pc;
  assign bus.id_ex_op1     = idex_q.op1;
  assign bus.id_ex_op2     = idex_q.op2;
  assign bus.id_ex_rs1     = idex_q.rs1;
  assign bus.id_ex_rs2     = idex_q.rs2;
  assign bus.id_ex_rd      = idex_q.rd;
  assign bus.id_ex_imm     = idex_q.imm;
  assign bus.id_ex_opcode  = idex_q.opcode;
  assign bus.id_ex_func3   = idex_q.func3;
  assign bus.id_ex_func7   = idex_q.func7;
  assign bus.id_ex_invalid = idex_q.invalid;
endmodule

// File: tb/tb_id_stage_piped.sv
// Scoreboard bench for id_stage_piped: one 32-register and one 16-register instance driven in lockstep.
module tb_id_stage_piped;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_piped_if #(.XLEN(32)) b32 ();
  id_stage_piped_if #(.XLEN(32)) b16 ();

  id_stage_piped #(.XLEN(32), .NUM_REGS(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  id_stage_piped #(.XLEN(32), .NUM_REGS(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  typedef struct {
    string       name;
    bit          sel;
    bit          valid;
    bit          invalid;
    logic [6:0]  opcode;
    bit          c_ops;  logic [31:0] op1, op2;
    bit          c_imm;  logic [31:0] imm;
    bit          c_rd;   logic [4:0]  rd;
    bit          c_rs;   logic [4:0]  rs1, rs2;
    bit          c_pc;   logic [31:0] pc;
    bit          c_fn;   logic [2:0]  f3; logic [6:0] f7;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  function automatic exp_t ex(string n, bit sel, bit v, bit inv, logic [6:0] opc);
    exp_t e;
    e = '{name: n, sel: sel, valid: v, invalid: inv, opcode: opc,
          c_ops: 0, op1: 0, op2: 0, c_imm: 0, imm: 0, c_rd: 0, rd: 0,
          c_rs: 0, rs1: 0, rs2: 0, c_pc: 0, pc: 0, c_fn: 0, f3: 0, f7: 0};
    return e;
  endfunction

  function automatic exp_t all_zero(string n, logic [6:0] opc);
    exp_t e;
    e = ex(n, 0, 0, 0, opc);
    e.c_ops = 1; e.c_imm = 1; e.c_rd = 1; e.c_rs = 1; e.c_pc = 1; e.c_fn = 1;
    return e;
  endfunction

  function automatic logic [31:0] rtype(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", n, act, exv);
    end
  endtask

  task automatic step(bit r, bit v, logic [31:0] ins, logic [31:0] pc, bit st, bit fl,
                      bit we, logic [4:0] wa, logic [31:0] wd);
    @(negedge clk);
    rst = r;
    b32.if_valid = v;  b32.instruction_in = ins; b32.pc_in = pc; b32.id_stall = st; b32.id_flush = fl;
    b32.reg_file_wr_en = we; b32.reg_file_wr_addr = wa; b32.reg_file_wr_data = wd;
    b16.if_valid = v;  b16.instruction_in = ins; b16.pc_in = pc; b16.id_stall = st; b16.id_flush = fl;
    b16.reg_file_wr_en = we; b16.reg_file_wr_addr = wa; b16.reg_file_wr_data = wd;
  endtask

  // Monitor: the ID/EX register presents a new value every edge; pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel) begin
          chk({e.name, ".valid"},   32'(b16.id_ex_valid),   32'(e.valid));
          chk({e.name, ".invalid"}, 32'(b16.id_ex_invalid), 32'(e.invalid));
          chk({e.name, ".opcode"},  32'(b16.id_ex_opcode),  32'(e.opcode));
          if (e.c_ops) chk({e.name, ".op1"}, b16.id_ex_op1, e.op1);
          $display("txn %s dut16 valid=%0b invalid=%0b opcode=%h op1=%h",
                   e.name, b16.id_ex_valid, b16.id_ex_invalid, b16.id_ex_opcode, b16.id_ex_op1);
        end else begin
          chk({e.name, ".valid"},   32'(b32.id_ex_valid),   32'(e.valid));
          chk({e.name, ".invalid"}, 32'(b32.id_ex_invalid), 32'(e.invalid));
          chk({e.name, ".opcode"},  32'(b32.id_ex_opcode),  32'(e.opcode));
          if (e.c_ops) begin
            chk({e.name, ".op1"}, b32.id_ex_op1, e.op1);
            chk({e.name, ".op2"}, b32.id_ex_op2, e.op2);
          end
          if (e.c_imm) chk({e.name, ".imm"}, b32.id_ex_imm, e.imm);
          if (e.c_rd)  chk({e.name, ".rd"}, 32'(b32.id_ex_rd), 32'(e.rd));
          if (e.c_rs) begin
            chk({e.name, ".rs1"}, 32'(b32.id_ex_rs1), 32'(e.rs1));
            chk({e.name, ".rs2"}, 32'(b32.id_ex_rs2), 32'(e.rs2));
          end
          if (e.c_pc)  chk({e.name, ".pc"}, b32.id_ex_pc, e.pc);
          if (e.c_fn) begin
            chk({e.name, ".func3"}, 32'(b32.id_ex_func3), 32'(e.f3));
            chk({e.name, ".func7"}, 32'(b32.id_ex_func7), 32'(e.f7));
          end
          $display("txn %s dut32 valid=%0b invalid=%0b opcode=%h op1=%h op2=%h imm=%h pc=%h",
                   e.name, b32.id_ex_valid, b32.id_ex_invalid, b32.id_ex_opcode,
                   b32.id_ex_op1, b32.id_ex_op2, b32.id_ex_imm, b32.id_ex_pc);
        end
      end
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    b32.if_valid = 0; b32.instruction_in = 0; b32.pc_in = 0; b32.id_stall = 0; b32.id_flush = 0;
    b32.reg_file_wr_en = 0; b32.reg_file_wr_addr = 0; b32.reg_file_wr_data = 0;
    b16.if_valid = 0; b16.instruction_in = 0; b16.pc_in = 0; b16.id_stall = 0; b16.id_flush = 0;
    b16.reg_file_wr_en = 0; b16.reg_file_wr_addr = 0; b16.reg_file_wr_data = 0;

    // Reset held for two cycles, instruction inputs busy to prove reset wins.
    step(1, 1, 32'h123450B7, 32'h44, 0, 0, 0, 0, 0);  sb.push_back(all_zero("rst0", 7'h00));
    step(1, 1, 32'h123450B7, 32'h48, 0, 0, 0, 0, 0);  sb.push_back(all_zero("rst1", 7'h00));

    // Every register reads back 0 after reset.
    for (int i = 1; i < 32; i += 2) begin
      step(0, 1, rtype(5'd1, 5'(i), 5'((i + 1) % 32)), 32'h100, 0, 0, 0, 0, 0);
      e = ex($sformatf("rd0_x%0d", i), 0, 1, 0, 7'h33);
      e.c_ops = 1; e.op1 = 0; e.op2 = 0;
      e.c_rs = 1; e.rs1 = 5'(i); e.rs2 = 5'((i + 1) % 32);
      sb.push_back(e);
    end

    // Write x5 with a bubble in decode: if_valid=0 must produce ADDI-shaped, non-valid output.
    step(0, 0, 32'hFFFFFFFF, 32'h1FC, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    e = ex("wr_x5_bubble", 0, 0, 0, 7'h13); e.c_imm = 1; e.imm = 0; e.c_rd = 1; e.rd = 0;
    sb.push_back(e);

    step(0, 1, 32'h00028333, 32'h200, 0, 0, 0, 0, 0);
    e = ex("add_x6_x5", 0, 1, 0, 7'h33);
    e.c_ops = 1; e.op1 = 32'hDEADBEEF; e.op2 = 0; e.c_rd = 1; e.rd = 6;
    e.c_rs = 1; e.rs1 = 5; e.rs2 = 0; e.c_pc = 1; e.pc = 32'h200; e.c_fn = 1; e.c_imm = 1; e.imm = 0;
    sb.push_back(e);

    step(0, 1, 32'h00028333, 32'h204, 0, 0, 1, 5'd5, 32'h00000055);
    e = ex("same_cycle_wr", 0, 1, 0, 7'h33); e.c_ops = 1; e.op2 = 0;
`ifdef ID_WB_BYPASS_EN
    e.op1 = 32'h00000055;
`else
    e.op1 = 32'hDEADBEEF;
`endif
    sb.push_back(e);

    step(0, 1, 32'h00028333, 32'h208, 0, 0, 0, 0, 0);
    e = ex("read_x5_new", 0, 1, 0, 7'h33); e.c_ops = 1; e.op1 = 32'h55; e.op2 = 0;
    sb.push_back(e);

    step(0, 1, rtype(5'd6, 5'd0, 5'd0), 32'h20C, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    e = ex("wr_x0_same", 0, 1, 0, 7'h33); e.c_ops = 1; e.op1 = 0; e.op2 = 0;
    sb.push_back(e);

    step(0, 1, rtype(5'd7, 5'd0, 5'd5), 32'h400, 0, 0, 0, 0, 0);
    e = ex("load_A", 0, 1, 0, 7'h33); e.c_ops = 1; e.op1 = 0; e.op2 = 32'h55;
    e.c_rd = 1; e.rd = 7; e.c_pc = 1; e.pc = 32'h400;
    sb.push_back(e);

    // Stall three cycles with B presented; the first stall cycle also writes x5.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h123450B7, 32'h500, 1, 0, (i == 0), 5'd5, 32'h00000077);
      e = ex($sformatf("stall_%0d", i), 0, 1, 0, 7'h33); e.c_ops = 1; e.op1 = 0; e.op2 = 32'h55;
      e.c_rd = 1; e.rd = 7; e.c_pc = 1; e.pc = 32'h400;
      sb.push_back(e);
    end

    step(0, 1, rtype(5'd7, 5'd0, 5'd5), 32'h404, 0, 0, 0, 0, 0);
    e = ex("wr_during_stall", 0, 1, 0, 7'h33); e.c_ops = 1; e.op1 = 0; e.op2 = 32'h77;
    e.c_pc = 1; e.pc = 32'h404;
    sb.push_back(e);

    step(0, 1, 32'h123450B7, 32'h600, 1, 1, 0, 0, 0);  sb.push_back(all_zero("flush_stall", 7'h13));

    step(0, 1, 32'hFE000EE3, 32'h300, 0, 0, 0, 0, 0);
    e = ex("beq_m4", 0, 1, 0, 7'h63); e.c_imm = 1; e.imm = 32'hFFFFFFFC; e.c_pc = 1; e.pc = 32'h300;
    sb.push_back(e);

    step(0, 1, 32'h123450B7, 32'h304, 0, 0, 0, 0, 0);
    e = ex("lui_x1", 0, 1, 0, 7'h37); e.c_imm = 1; e.imm = 32'h12345000; e.c_rd = 1; e.rd = 1;
    sb.push_back(e);

    step(0, 1, 32'h0020A423, 32'h308, 0, 0, 0, 0, 0);
    e = ex("sw_8", 0, 1, 0, 7'h23); e.c_imm = 1; e.imm = 32'h00000008;
    e.c_rs = 1; e.rs1 = 1; e.rs2 = 2;
    sb.push_back(e);

    step(0, 1, 32'hFFF10093, 32'h30C, 0, 0, 0, 0, 0);
    e = ex("addi_m1", 0, 1, 0, 7'h13); e.c_imm = 1; e.imm = 32'hFFFFFFFF; e.c_rd = 1; e.rd = 1;
    sb.push_back(e);

    step(0, 1, 32'hFFF10093, 32'h310, 0, 1, 0, 0, 0);  sb.push_back(all_zero("flush", 7'h13));

    // Register-count limits: x20 exists only in the 32-register build.
    step(0, 0, 32'h0, 32'h0, 0, 0, 1, 5'd20, 32'h00001234);
    sb.push_back(ex("wr_x20", 0, 0, 0, 7'h13));

    step(0, 1, rtype(5'd1, 5'd20, 5'd0), 32'h700, 0, 0, 0, 0, 0);
    e = ex("rv32e_rs1_x20", 1, 1, 1, 7'h33); e.c_ops = 1; e.op1 = 0;
    sb.push_back(e);

    step(0, 1, rtype(5'd1, 5'd20, 5'd0), 32'h704, 0, 0, 0, 0, 0);
    e = ex("rv32i_rs1_x20", 0, 1, 0, 7'h33); e.c_ops = 1; e.op1 = 32'h1234; e.op2 = 0;
    sb.push_back(e);

    step(0, 1, 32'h000A0013, 32'h708, 0, 0, 0, 0, 0);  sb.push_back(ex("rv32e_addi_x20", 1, 1, 1, 7'h13));
    step(0, 1, 32'h000A0013, 32'h70C, 0, 0, 0, 0, 0);  sb.push_back(ex("rv32i_addi_x20", 0, 1, 0, 7'h13));
    step(0, 1, 32'h0000007F, 32'h710, 0, 0, 0, 0, 0);  sb.push_back(ex("bad_opcode", 0, 1, 1, 7'h7F));
    step(0, 1, 32'h00000010, 32'h714, 0, 0, 0, 0, 0);  sb.push_back(ex("bad_low_bits", 0, 1, 1, 7'h10));
    step(0, 0, 32'h0000007F, 32'h718, 0, 0, 0, 0, 0);  sb.push_back(ex("rv32e_no_valid", 1, 0, 0, 7'h13));

    step(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0 pending entries", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout got=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
